sdio_cmd_arbiter: RTL and testbench

SDIO_CMD_ARBITER -- requirements
Module: sdio_cmd_arbiter

---
 rtl/sdio_cmd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sdio_cmd_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_arbiter.sv
// Two-requester round-robin arbiter sequencing one SDIO command at a time: clear, start, wait for eot, complete.
// Optional WAIT watchdog enabled by defining SDIO_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module sdio_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    input  logic [61:0] req0_desc_i,
    input  logic [61:0] req1_desc_i,
    output logic [1:0]  req_ready_o,
    output logic [1:0]  req_done_o,
    output logic [15:0] done_status_o,
    output logic        timeout_o,
    output logic        txrx_clr_stat_o,
    output logic        txrx_cmd_start_o,
    output logic [61:0] txrx_desc_o,
    input  logic        txrx_eot_i,
    input  logic [15:0] txrx_status_i
);

    localparam int unsigned DESC_W = 62;
    localparam int unsigned STAT_W = 16;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sdio_cmd_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic [STAT_W-1:0]   status_q, status_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                clr_q, clr_d;
    logic                start_q, start_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          ready_c;
    logic                pick_c;

`ifdef SDIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
`endif

    // Tie goes to the requester that was not served last
    assign pick_c = (&req_valid_i) ? ~last_q : req_valid_i[1];

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        status_d = status_q;
        grant_d  = grant_q;
        last_d   = last_q;
        clr_d    = 1'b0;
        start_d  = 1'b0;
        done_d   = 2'b00;
        ready_c  = 2'b00;
`ifdef SDIO_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid_i) begin
                    ready_c[pick_c] = 1'b1;
                    grant_d         = pick_c;
                    desc_d          = pick_c ? req1_desc_i : req0_desc_i;
                    clr_d           = 1'b1;
                    state_d         = S_CLR;
                end
            end
            S_CLR: begin
                start_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
`ifdef SDIO_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (txrx_eot_i) begin
                    status_d        = txrx_status_i;
                    done_d[grant_q] = 1'b1;
                    state_d         = S_DONE;
                end
`ifdef SDIO_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    status_d        = {STAT_W{1'b1}};
                    done_d[grant_q] = 1'b1;
                    timeout_d       = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            desc_q   <= '0;
            status_q <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            clr_q    <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 2'b00;
`ifdef SDIO_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            desc_q   <= desc_d;
            status_q <= status_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            clr_q    <= clr_d;
            start_q  <= start_d;
            done_q   <= done_d;
`ifdef SDIO_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Accept strobe is combinational so the handshake completes in the IDLE cycle
    assign req_ready_o      = rst_i ? 2'b00 : ready_c;
    assign req_done_o       = done_q;
    assign done_status_o    = status_q;
    assign txrx_clr_stat_o  = clr_q;
    assign txrx_cmd_start_o = start_q;
    assign txrx_desc_o      = desc_q;

`ifdef SDIO_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_cmd_arbiter.sv
// Directed bench for sdio_cmd_arbiter: single transfer timing, round-robin, stray eot, reset abort, watchdog.
module tb_sdio_cmd_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [61:0] req0_desc_i;
    logic [61:0] req1_desc_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_done_o;
    logic [15:0] done_status_o;
    logic        timeout_o;
    logic        txrx_clr_stat_o;
    logic        txrx_cmd_start_o;
    logic [61:0] txrx_desc_o;
    logic        txrx_eot_i;
    logic [15:0] txrx_status_i;

    int tests  = 0;
    int failed = 0;
    logic [1:0] seen_done;
    logic       seen_to;

    sdio_cmd_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req0_desc_i      (req0_desc_i),
        .req1_desc_i      (req1_desc_i),
        .req_ready_o      (req_ready_o),
        .req_done_o       (req_done_o),
        .done_status_o    (done_status_o),
        .timeout_o        (timeout_o),
        .txrx_clr_stat_o  (txrx_clr_stat_o),
        .txrx_cmd_start_o (txrx_cmd_start_o),
        .txrx_desc_o      (txrx_desc_o),
        .txrx_eot_i       (txrx_eot_i),
        .txrx_status_i    (txrx_status_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // {op, arg, rsp_type, data_en, data_rwn, data_quad, block_size, block_num}
        req0_desc_i   = {6'd17, 32'hA5A5_0001, 3'd1, 1'b1, 1'b0, 1'b1, 10'd512, 8'd4};
        req1_desc_i   = {6'd24, 32'h0000_BEEF, 3'd2, 1'b1, 1'b1, 1'b0, 10'd64,  8'd9};
        rst_i         = 1'b1;
        req_valid_i   = 2'b00;
        txrx_eot_i    = 1'b0;
        txrx_status_i = 16'h0000;

        // Reset: everything quiet, ready blocked even with a pending request
        cyc();
        cyc();
        req_valid_i = 2'b01;
        settle();
        chk("rst_ready",  64'(req_ready_o), 64'd0);
        chk("rst_done",   64'(req_done_o), 64'd0);
        chk("rst_clr",    64'(txrx_clr_stat_o), 64'd0);
        chk("rst_start",  64'(txrx_cmd_start_o), 64'd0);
        chk("rst_desc",   64'(txrx_desc_o), 64'd0);
        chk("rst_status", 64'(done_status_o), 64'd0);
        chk("rst_to",     64'(timeout_o), 64'd0);

        // Single transfer from requester 0, eot 10 cycles after start
        cyc();
        rst_i = 1'b0;
        settle();
        chk("t1_ready_c0", 64'(req_ready_o), 64'd1);
        cyc();
        req_valid_i = 2'b00;
        settle();
        chk("t1_clr_c1",   64'(txrx_clr_stat_o), 64'd1);
        chk("t1_start_c1", 64'(txrx_cmd_start_o), 64'd0);
        chk("t1_ready_c1", 64'(req_ready_o), 64'd0);
        chk("t1_desc_c1",  64'(txrx_desc_o), 64'(req0_desc_i));
        cyc();
        settle();
        chk("t1_start_c2", 64'(txrx_cmd_start_o), 64'd1);
        chk("t1_clr_c2",   64'(txrx_clr_stat_o), 64'd0);
        seen_done = 2'b00;
        for (int i = 3; i <= 11; i++) begin
            cyc();
            settle();
            seen_done |= req_done_o;
        end
        chk("t1_no_early_done", 64'(seen_done), 64'd0);
        cyc();
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h0012;
        settle();
        chk("t1_done_c12", 64'(req_done_o), 64'd0);
        cyc();
        txrx_eot_i    = 1'b0;
        txrx_status_i = 16'h7777;
        settle();
        chk("t1_done_c13",   64'(req_done_o), 64'd1);
        chk("t1_status_c13", 64'(done_status_o), 64'h0012);
        chk("t1_desc_c13",   64'(txrx_desc_o), 64'(req0_desc_i));
        chk("t1_to_c13",     64'(timeout_o), 64'd0);
        cyc();
        settle();
        chk("t1_done_c14",   64'(req_done_o), 64'd0);
        chk("t1_status_hold", 64'(done_status_o), 64'h0012);

        // Stray eot during CLR must be ignored
        cyc();
        req_valid_i = 2'b10;
        settle();
        chk("t2_ready", 64'(req_ready_o), 64'd2);
        cyc();
        req_valid_i   = 2'b00;
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'hDEAD;
        settle();
        chk("t2_clr", 64'(txrx_clr_stat_o), 64'd1);
        cyc();
        txrx_eot_i = 1'b0;
        settle();
        chk("t2_start", 64'(txrx_cmd_start_o), 64'd1);
        cyc();
        settle();
        chk("t2_no_done_wait", 64'(req_done_o), 64'd0);
        cyc();
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'hBEEF;
        settle();
        chk("t2_no_done_eot", 64'(req_done_o), 64'd0);
        cyc();
        txrx_eot_i = 1'b0;
        settle();
        chk("t2_done",   64'(req_done_o), 64'd2);
        chk("t2_status", 64'(done_status_o), 64'hBEEF);
        seen_done = 2'b00;
        for (int i = 0; i < 5; i++) begin
            cyc();
            settle();
            seen_done |= req_done_o;
        end
        chk("t2_single_done", 64'(seen_done), 64'd0);

        // Both requesters valid continuously out of reset: 0,1,0,1
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i       = 1'b0;
        req_valid_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            settle();
            chk($sformatf("rr%0d_ready", t), 64'(req_ready_o), (t % 2 == 0) ? 64'd1 : 64'd2);
            cyc();
            settle();
            chk($sformatf("rr%0d_desc", t), 64'(txrx_desc_o),
                (t % 2 == 0) ? 64'(req0_desc_i) : 64'(req1_desc_i));
            cyc();
            cyc();
            txrx_eot_i    = 1'b1;
            txrx_status_i = 16'h0100 + 16'(t);
            cyc();
            txrx_eot_i = 1'b0;
            if (t == 3) req_valid_i = 2'b00;
            settle();
            chk($sformatf("rr%0d_done", t), 64'(req_done_o), (t % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("rr%0d_status", t), 64'(done_status_o), 64'h0100 + 64'(t));
            cyc();
        end

        // Reset during WAIT aborts the transfer; stale eot afterwards is ignored
        req_valid_i = 2'b01;
        settle();
        chk("t4_ready", 64'(req_ready_o), 64'd1);
        cyc();
        req_valid_i = 2'b00;
        cyc();
        cyc();
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i         = 1'b0;
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h1234;
        settle();
        chk("t4_clr",    64'(txrx_clr_stat_o), 64'd0);
        chk("t4_start",  64'(txrx_cmd_start_o), 64'd0);
        chk("t4_desc",   64'(txrx_desc_o), 64'd0);
        chk("t4_status", 64'(done_status_o), 64'd0);
        chk("t4_to",     64'(timeout_o), 64'd0);
        seen_done = req_done_o;
        cyc();
        txrx_eot_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            seen_done |= req_done_o;
            cyc();
        end
        chk("t4_no_done", 64'(seen_done), 64'd0);
        req_valid_i = 2'b10;
        settle();
        chk("t4_r1_ready", 64'(req_ready_o), 64'd2);
        cyc();
        req_valid_i = 2'b00;
        settle();
        chk("t4_r1_clr",  64'(txrx_clr_stat_o), 64'd1);
        chk("t4_r1_desc", 64'(txrx_desc_o), 64'(req1_desc_i));
        cyc();
        cyc();
        txrx_eot_i    = 1'b1;
        txrx_status_i = 16'h5A5A;
        cyc();
        txrx_eot_i = 1'b0;
        settle();
        chk("t4_r1_done",   64'(req_done_o), 64'd2);
        chk("t4_r1_status", 64'(done_status_o), 64'h5A5A);

        // Watchdog: no eot ever arrives
        cyc();
        req_valid_i = 2'b01;
        settle();
        chk("t5_ready", 64'(req_ready_o), 64'd1);
        cyc();
        req_valid_i = 2'b00;
        cyc();
        seen_done = 2'b00;
        seen_to   = 1'b0;
`ifdef SDIO_ARB_TIMEOUT_EN
        for (int i = 3; i <= 11; i++) begin
            cyc();
            settle();
            seen_done |= req_done_o;
            seen_to   |= timeout_o;
        end
        chk("t5_no_early_done", 64'(seen_done), 64'd0);
        chk("t5_no_early_to",   64'(seen_to), 64'd0);
        cyc();
        settle();
        chk("t5_done",   64'(req_done_o), 64'd1);
        chk("t5_to",     64'(timeout_o), 64'd1);
        chk("t5_status", 64'(done_status_o), 64'hFFFF);
        cyc();
        settle();
        chk("t5_to_clear",   64'(timeout_o), 64'd0);
        chk("t5_done_clear", 64'(req_done_o), 64'd0);
`else
        for (int i = 3; i <= 40; i++) begin
            cyc();
            settle();
            seen_done |= req_done_o;
            seen_to   |= timeout_o;
        end
        chk("t5_never_done", 64'(seen_done), 64'd0);
        chk("t5_never_to",   64'(seen_to), 64'd0);
        chk("t5_status_kept", 64'(done_status_o), 64'h5A5A);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
